// File: rtl/demux4way1_stream_pkg.sv
// ---------------------------------------------------------------------------
// demux4way1_stream_pkg
//   Shared constants and types for the 1-to-4 stream demultiplexer.
//   NUM_LANES  : number of output lanes
//   SEL_W      : width of the lane select
//   lane_occ_t : occupancy state of one 2-entry lane FIFO
// ---------------------------------------------------------------------------
package demux4way1_stream_pkg;

    localparam int NUM_LANES = 4;
    localparam int SEL_W     = 2;

    typedef enum logic [1:0] {
        LANE_EMPTY = 2'd0,
        LANE_ONE   = 2'd1,
        LANE_FULL  = 2'd2
    } lane_occ_t;

endpackage

// File: rtl/demux4way1_stream_lane_fifo2.sv
// ---------------------------------------------------------------------------
// lane_fifo2
//   Two-entry head/tail FIFO for one output lane. The head register drives
//   dout directly, so the consumer sees a registered word with no mux.
//
//   clk   : clock, all state changes on rising edge
//   reset : synchronous active-high reset, clears occupancy and both entries
//   push  : write din this cycle (caller guarantees !full)
//   pop   : consumer takes the head this cycle (caller guarantees valid)
//   din   : word to write
//   dout  : head word (stale when empty)
//   valid : head entry holds a word
//   full  : both entries hold words
// ---------------------------------------------------------------------------
module lane_fifo2
    import demux4way1_stream_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             valid,
    output logic             full
);

    lane_occ_t        occ;
    logic [WIDTH-1:0] head;
    logic [WIDTH-1:0] tail;

    always_ff @(posedge clk) begin
        if (reset) begin
            occ  <= LANE_EMPTY;
            head <= '0;
            tail <= '0;
        end else begin
            case (occ)
                LANE_EMPTY: begin
                    if (push) begin
                        head <= din;
                        occ  <= LANE_ONE;
                    end
                end
                LANE_ONE: begin
                    // With a simultaneous pop the new word becomes the head
                    // directly; the tail is only used when both are held.
                    if (push && pop) begin
                        head <= din;
                    end else if (push) begin
                        tail <= din;
                        occ  <= LANE_FULL;
                    end else if (pop) begin
                        occ  <= LANE_EMPTY;
                    end
                end
                LANE_FULL: begin
                    if (pop) begin
                        head <= tail;
                        occ  <= LANE_ONE;
                    end
                end
                default: occ <= LANE_EMPTY;
            endcase
        end
    end

    assign dout  = head;
    assign valid = (occ != LANE_EMPTY);
    assign full  = (occ == LANE_FULL);

endmodule

// File: rtl/demux4way1_stream.sv
// ---------------------------------------------------------------------------
// demux4way1_stream
//   Registered 1-to-4 stream demultiplexer. Each accepted input word is
//   steered by in_sel into one of four 2-entry lane FIFOs. in_ready depends
//   only on in_sel and registered lane occupancy, so there is no
//   combinational path from out_ready to in_ready.
//
//   clk          : clock
//   reset        : synchronous active-high reset
//   in_valid     : producer has a word
//   in_sel       : destination lane for in_data
//   in_data      : input word
//   in_ready     : selected lane has room
//   out_valid    : bit i set when lane i head is valid
//   out_ready    : bit i set when lane i consumer takes the head
//   out_data0..3 : head word of each lane
//   accept_count : words accepted since reset, wraps modulo 2^COUNT_W
// ---------------------------------------------------------------------------
module demux4way1_stream
    import demux4way1_stream_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int COUNT_W = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    input  logic [SEL_W-1:0]     in_sel,
    input  logic [WIDTH-1:0]     in_data,
    output logic                 in_ready,
    output logic [NUM_LANES-1:0] out_valid,
    input  logic [NUM_LANES-1:0] out_ready,
    output logic [WIDTH-1:0]     out_data0,
    output logic [WIDTH-1:0]     out_data1,
    output logic [WIDTH-1:0]     out_data2,
    output logic [WIDTH-1:0]     out_data3,
    output logic [COUNT_W-1:0]   accept_count
);

    localparam logic [COUNT_W-1:0] COUNT_ONE = COUNT_W'(1);

    logic [NUM_LANES-1:0] lane_full;
    logic [NUM_LANES-1:0] push;
    logic [NUM_LANES-1:0] pop;
    logic [WIDTH-1:0]     lane_data [NUM_LANES];
    logic                 in_xfer;

    assign in_ready = !lane_full[in_sel];
    assign in_xfer  = in_valid && in_ready;

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        assign push[i] = in_xfer && (in_sel == SEL_W'(i));
        assign pop[i]  = out_valid[i] && out_ready[i];

        lane_fifo2 #(
            .WIDTH (WIDTH)
        ) u_lane (
            .clk   (clk),
            .reset (reset),
            .push  (push[i]),
            .pop   (pop[i]),
            .din   (in_data),
            .dout  (lane_data[i]),
            .valid (out_valid[i]),
            .full  (lane_full[i])
        );
    end

    assign out_data0 = lane_data[0];
    assign out_data1 = lane_data[1];
    assign out_data2 = lane_data[2];
    assign out_data3 = lane_data[3];

    always_ff @(posedge clk) begin
        if (reset) begin
            accept_count <= '0;
        end else if (in_xfer) begin
            accept_count <= accept_count + COUNT_ONE;
        end
    end

endmodule

// File: tb/tb_demux4way1_stream.sv
// ---------------------------------------------------------------------------
// tb_demux4way1_stream
//   Self-checking bench for demux4way1_stream (WIDTH = 8, COUNT_W = 4).
//   A queue-per-lane reference model predicts every output each cycle.
// ---------------------------------------------------------------------------
module tb_demux4way1_stream;

    localparam int W  = 8;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic [1:0]    in_sel;
    logic [W-1:0]  in_data;
    logic          in_ready;
    logic [3:0]    out_valid;
    logic [3:0]    out_ready;
    logic [W-1:0]  out_data0, out_data1, out_data2, out_data3;
    logic [CW-1:0] accept_count;

    demux4way1_stream #(
        .WIDTH   (W),
        .COUNT_W (CW)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_sel       (in_sel),
        .in_data      (in_data),
        .in_ready     (in_ready),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data0    (out_data0),
        .out_data1    (out_data1),
        .out_data2    (out_data2),
        .out_data3    (out_data3),
        .accept_count (accept_count)
    );

    always #5 clk = ~clk;

    logic [W-1:0] od [4];
    assign od[0] = out_data0;
    assign od[1] = out_data1;
    assign od[2] = out_data2;
    assign od[3] = out_data3;

    // Reference model: one FIFO queue per lane, the word last removed from
    // each lane (what an empty lane keeps showing), and a wrapping count.
    logic [W-1:0] q [4][$];
    logic [W-1:0] stale [4];
    int           cnt;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int l = 0; l < 4; l++) begin
            q[l].delete();
            stale[l] = '0;
        end
        cnt = 0;
    endtask

    task automatic setin(input logic v, input logic [1:0] s, input logic [W-1:0] d,
                         input logic [3:0] ordy, input logic rst);
        in_valid  = v;
        in_sel    = s;
        in_data   = d;
        out_ready = ordy;
        reset     = rst;
        #1;
    endtask

    // Compare every output with the model, clock once, advance the model.
    task automatic tick();
        logic         exp_rdy;
        logic [3:0]   exp_vld;
        logic [W-1:0] exp_d;
        logic         do_push;
        logic [3:0]   do_pop;
        exp_rdy = (q[in_sel].size() < 2);
        for (int l = 0; l < 4; l++) begin
            exp_vld[l] = (q[l].size() != 0);
            exp_d      = exp_vld[l] ? q[l][0] : stale[l];
            chk($sformatf("data%0d", l), od[l], exp_d);
            do_pop[l]  = exp_vld[l] && out_ready[l];
        end
        chk("out_valid", out_valid, exp_vld);
        chk("in_ready", in_ready, exp_rdy);
        chk("accept_count", accept_count, cnt);
        do_push = in_valid && exp_rdy;
        @(posedge clk);
        if (reset) begin
            model_reset();
        end else begin
            for (int l = 0; l < 4; l++) begin
                if (do_pop[l]) stale[l] = q[l].pop_front();
            end
            if (do_push) begin
                q[in_sel].push_back(in_data);
                cnt = (cnt + 1) % (1 << CW);
            end
        end
        @(negedge clk);
    endtask

    task automatic drive(input logic v, input logic [1:0] s, input logic [W-1:0] d,
                         input logic [3:0] ordy, input logic rst);
        setin(v, s, d, ordy, rst);
        tick();
    endtask

    initial begin
        // Reset held two cycles with in_valid high.
        setin(1'b1, 2'd3, 8'hFF, 4'hF, 1'b1);
        @(posedge clk);
        model_reset();
        @(negedge clk);
        drive(1'b1, 2'd3, 8'hFF, 4'hF, 1'b1);
        setin(1'b0, 2'd0, 8'h00, 4'hF, 1'b0);
        chk("rst_out_valid", out_valid, 4'b0000);
        chk("rst_data0", out_data0, 8'h00);
        chk("rst_data3", out_data3, 8'h00);
        chk("rst_count", accept_count, 0);
        chk("rst_in_ready", in_ready, 1'b1);

        // Routing: one word to each lane, consumers always ready.
        for (int s = 0; s < 4; s++) drive(1'b1, 2'(s), 8'hA0 + 8'(s), 4'hF, 1'b0);
        setin(1'b0, 2'd0, 8'h00, 4'hF, 1'b0);
        chk("route_count", accept_count, 4);
        chk("route_last_lane3", out_data3, 8'hA3);
        chk("route_vld3_only", out_valid, 4'b1000);
        tick();

        // Full lane: two words fill lane 2, the third is refused.
        drive(1'b1, 2'd2, 8'h11, 4'h0, 1'b0);
        drive(1'b1, 2'd2, 8'h22, 4'h0, 1'b0);
        setin(1'b1, 2'd2, 8'h33, 4'h0, 1'b0);
        chk("full_in_ready", in_ready, 1'b0);
        chk("full_head2", out_data2, 8'h11);
        tick();
        setin(1'b1, 2'd1, 8'h33, 4'h0, 1'b0);
        chk("other_lane_ready", in_ready, 1'b1);
        tick();
        setin(1'b0, 2'd0, 8'h00, 4'b0100, 1'b0);
        chk("lane1_word", out_data1, 8'h33);

        // Drain lane 2 in order.
        tick();
        setin(1'b0, 2'd0, 8'h00, 4'b0100, 1'b0);
        chk("drain_second", out_data2, 8'h22);
        tick();
        setin(1'b0, 2'd0, 8'h00, 4'b0000, 1'b0);
        chk("drain_empty", out_valid[2], 1'b0);

        // Simultaneous push and pop on lane 0 while it holds one word.
        drive(1'b1, 2'd0, 8'h55, 4'b0000, 1'b0);
        setin(1'b1, 2'd0, 8'h66, 4'b0001, 1'b0);
        chk("pp_head_before", out_data0, 8'h55);
        tick();
        setin(1'b0, 2'd0, 8'h00, 4'b0000, 1'b0);
        chk("pp_valid", out_valid[0], 1'b1);
        chk("pp_head_after", out_data0, 8'h66);
        tick();

        // Counter wrap: 17 accepted words from reset give count 1.
        drive(1'b0, 2'd0, 8'h00, 4'hF, 1'b1);
        for (int k = 0; k < 17; k++) drive(1'b1, 2'(k), 8'(k + 8'h40), 4'hF, 1'b0);
        setin(1'b0, 2'd0, 8'h00, 4'h0, 1'b0);
        chk("wrap_count", accept_count, 1);
        tick();

        // Mid-operation reset with non-empty lanes, consumers ready.
        drive(1'b1, 2'd0, 8'h77, 4'h0, 1'b0);
        drive(1'b1, 2'd3, 8'h88, 4'h0, 1'b0);
        drive(1'b1, 2'd0, 8'h99, 4'hF, 1'b1);
        setin(1'b0, 2'd0, 8'h00, 4'h0, 1'b0);
        chk("midrst_valid", out_valid, 4'b0000);
        chk("midrst_count", accept_count, 0);
        tick();

        // Randomized traffic with occasional reset.
        for (int k = 0; k < 400; k++) begin
            drive(1'($urandom_range(0, 3) != 0), 2'($urandom), 8'($urandom),
                  4'($urandom), 1'($urandom_range(0, 59) == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
